i2c_slave_ctrl: RTL and testbench

I2C_SLAVE_CTRL -- requirements
Module: i2c_slave_ctrl

---
 rtl/i2c_slave_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_i2c_slave_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_ctrl.sv
// I2C target controller: 7-bit addressing, byte receive/transmit with ACK handling.
// Optional 3-sample SCL/SDA majority filter enabled by I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave_ctrl #(
  parameter logic [6:0] SLAVE_ADDR = 7'h3C
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       i2c_sclk,
  inout  wire        i2c_sdat,
  output logic [7:0] Rx_DATA,
  output logic       Rx_Valid,
  input  logic [7:0] Tx_DATA,
  output logic       Tx_Req,
  output logic       Addr_Hit,
  output logic       Rw,
  output logic       Busy,
  output logic       Stop_Det
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX_BYTE,
    RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
  } state_t;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] sh, sh_n;
  logic [7:0] tx_sh, tx_n;
  logic       oe, oe_n;
  logic [7:0] rxd_n;
  logic       rxv_n, txr_n, hit_n;
  logic       rw_n, busy_n, stop_n;
  logic [7:0] byte_in;

  logic [1:0] scl_sy, sda_sy;
  logic       scl_c, sda_c, scl_p, sda_p;

  assign i2c_sdat = oe ? 1'b0 : 1'bz;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      scl_sy <= '1;
      sda_sy <= '1;
      scl_p  <= 1'b1;
      sda_p  <= 1'b1;
    end else begin
      scl_sy <= {scl_sy[0], i2c_sclk};
      sda_sy <= {sda_sy[0], i2c_sdat};
      scl_p  <= scl_c;
      sda_p  <= sda_c;
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_w, sda_w;
  logic       scl_f, sda_f;

  // Output follows the majority of the last three synchronized samples.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      scl_w <= '1;
      sda_w <= '1;
      scl_f <= 1'b1;
      sda_f <= 1'b1;
    end else begin
      scl_w <= {scl_w[0], scl_sy[1]};
      sda_w <= {sda_w[0], sda_sy[1]};
      scl_f <= (scl_sy[1] & scl_w[0]) | (scl_sy[1] & scl_w[1]) | (scl_w[0] & scl_w[1]);
      sda_f <= (sda_sy[1] & sda_w[0]) | (sda_sy[1] & sda_w[1]) | (sda_w[0] & sda_w[1]);
    end
  end

  assign scl_c = scl_f;
  assign sda_c = sda_f;
`else
  assign scl_c = scl_sy[1];
  assign sda_c = sda_sy[1];
`endif

  logic rise, fall, start_ev, stop_ev;
  assign rise     = scl_c & ~scl_p;
  assign fall     = ~scl_c & scl_p;
  assign start_ev = scl_c & scl_p & sda_p & ~sda_c;
  assign stop_ev  = scl_c & scl_p & ~sda_p & sda_c;
  assign byte_in  = {sh[6:0], sda_c};

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    tx_n    = tx_sh;
    oe_n    = oe;
    rxd_n   = Rx_DATA;
    rxv_n   = 1'b0;
    txr_n   = 1'b0;
    hit_n   = 1'b0;
    rw_n    = Rw;
    busy_n  = Busy;
    stop_n  = 1'b0;
    if (stop_ev) begin
      state_n = IDLE;
      oe_n    = 1'b0;
      cnt_n   = '0;
      busy_n  = 1'b0;
      stop_n  = 1'b1;
    end else if (start_ev) begin
      state_n = ADDR;
      oe_n    = 1'b0;
      cnt_n   = '0;
      busy_n  = 1'b1;
    end else begin
      unique case (state)
        ADDR: if (rise) begin
          sh_n  = byte_in;
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd7) begin
            cnt_n = '0;
            // Address 0 (general call) is never acknowledged.
            if (byte_in[7:1] == SLAVE_ADDR && byte_in[7:1] != 7'd0) begin
              rw_n    = byte_in[0];
              hit_n   = 1'b1;
              state_n = ADDR_ACK;
            end else begin
              state_n = WAIT_STOP;
            end
          end
        end
        ADDR_ACK: begin
          if (rise && cnt == 4'd1 && Rw) txr_n = 1'b1;
          if (fall) begin
            if (cnt == 4'd0) begin
              oe_n  = 1'b1;
              cnt_n = 4'd1;
            end else begin
              cnt_n = '0;
              if (Rw) begin
                tx_n    = Tx_DATA;
                oe_n    = ~Tx_DATA[7];
                state_n = TX_BYTE;
              end else begin
                oe_n    = 1'b0;
                state_n = RX_BYTE;
              end
            end
          end
        end
        RX_BYTE: if (rise) begin
          sh_n  = byte_in;
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd7) begin
            cnt_n   = '0;
            rxd_n   = byte_in;
            rxv_n   = 1'b1;
            state_n = RX_ACK;
          end
        end
        RX_ACK: if (fall) begin
          if (cnt == 4'd0) begin
            oe_n  = 1'b1;
            cnt_n = 4'd1;
          end else begin
            oe_n    = 1'b0;
            cnt_n   = '0;
            state_n = RX_BYTE;
          end
        end
        TX_BYTE: if (fall) begin
          if (cnt == 4'd7) begin
            oe_n    = 1'b0;
            cnt_n   = '0;
            state_n = TX_ACK;
          end else begin
            cnt_n = cnt + 4'd1;
            tx_n  = {tx_sh[6:0], 1'b0};
            oe_n  = ~tx_sh[6];
          end
        end
        TX_ACK: begin
          if (rise && cnt == 4'd0) begin
            if (!sda_c) begin
              txr_n = 1'b1;
              cnt_n = 4'd1;
            end else begin
              state_n = WAIT_STOP;
            end
          end else if (fall && cnt == 4'd1) begin
            tx_n    = Tx_DATA;
            oe_n    = ~Tx_DATA[7];
            cnt_n   = '0;
            state_n = TX_BYTE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      sh       <= '0;
      tx_sh    <= '0;
      oe       <= 1'b0;
      Rx_DATA  <= '0;
      Rx_Valid <= 1'b0;
      Tx_Req   <= 1'b0;
      Addr_Hit <= 1'b0;
      Rw       <= 1'b0;
      Busy     <= 1'b0;
      Stop_Det <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sh       <= sh_n;
      tx_sh    <= tx_n;
      oe       <= oe_n;
      Rx_DATA  <= rxd_n;
      Rx_Valid <= rxv_n;
      Tx_Req   <= txr_n;
      Addr_Hit <= hit_n;
      Rw       <= rw_n;
      Busy     <= busy_n;
      Stop_Det <= stop_n;
    end
  end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Bench for i2c_slave_ctrl: bus-level master model, queue scoreboard, random traffic.
module tb_i2c_slave_ctrl;

  localparam int QT = 160;
  localparam logic [6:0] MY = 7'h3C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, addr_hit, rw, busy, stop_det;
  wire        sda;

  pullup (sda);
  assign sda = sda_low ? 1'b0 : 1'bz;

  i2c_slave_ctrl #(.SLAVE_ADDR(MY)) dut (
    .Clk(clk), .Rst_n(rst_n), .i2c_sclk(scl_m), .i2c_sdat(sda),
    .Rx_DATA(rx_data), .Rx_Valid(rx_valid), .Tx_DATA(tx_data),
    .Tx_Req(tx_req), .Addr_Hit(addr_hit), .Rw(rw), .Busy(busy),
    .Stop_Det(stop_det)
  );

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int stop_cnt = 0;
  int exp_stop = 0;
  int glitch_bit = -1;
  logic [7:0] exp_rx[$];
  logic       exp_rw[$];
  logic [7:0] tx_q[$];
  logic [7:0] dbuf[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rx_valid) begin
      if (exp_rx.size() == 0) chk("rx_valid_unexpected", 1, 0);
      else chk("rx_data", rx_data, exp_rx.pop_front());
    end
    if (addr_hit) begin
      if (exp_rw.size() == 0) chk("addr_hit_unexpected", 1, 0);
      else chk("addr_hit_rw", rw, exp_rw.pop_front());
    end
    if (tx_req) begin
      if (tx_q.size() == 0) chk("tx_req_unexpected", 1, 0);
      else tx_data = tx_q.pop_front();
    end
    if (stop_det) stop_cnt++;
  end

  task automatic wq;
    #(QT);
  endtask

  task automatic m_start;
    sda_low = 1'b0; scl_m = 1'b1; wq;
    sda_low = 1'b1; wq;
    scl_m = 1'b0; wq;
  endtask

  task automatic m_rstart;
    sda_low = 1'b0; wq;
    scl_m = 1'b1; wq;
    sda_low = 1'b1; wq;
    scl_m = 1'b0; wq;
  endtask

  task automatic m_stop;
    sda_low = 1'b1; wq;
    scl_m = 1'b1; wq;
    sda_low = 1'b0; wq;
  endtask

  task automatic m_bit(input logic b, input bit gl, output logic r);
    sda_low = ~b; wq;
    scl_m = 1'b1;
    if (gl) begin
      #60 scl_m = 1'b0;
      #20 scl_m = 1'b1;
      #80;
    end else wq;
    r = sda; wq;
    scl_m = 1'b0; wq;
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) m_bit(b[i], (i == glitch_bit), r);
    m_bit(1'b1, 1'b0, ack);
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, 1'b0, r);
      b[i] = r;
    end
    m_bit(nack, 1'b0, r);
  endtask

  // Reference: a target at MY acks its address and every written byte,
  // and returns queued bytes on reads; anything else is ignored.
  task automatic xfer(input logic [7:0] ab, input int n, input bit rs, input bit stp);
    logic ack;
    logic [7:0] rb;
    bit hit;
    hit = (ab[7:1] == MY);
    if (hit) exp_rw.push_back(ab[0]);
    if (hit && ab[0]) for (int i = 0; i < n; i++) tx_q.push_back(dbuf[i]);
    if (rs) m_rstart; else m_start;
    wr_byte(ab, ack);
    chk("addr_ack", ack, hit ? 0 : 1);
    chk("busy_in_xfer", busy, 1);
    if (hit && ab[0]) begin
      for (int i = 0; i < n; i++) begin
        rd_byte(i == n - 1, rb);
        chk("read_byte", rb, dbuf[i]);
      end
      chk("tx_req_count", tx_q.size(), 0);
    end else begin
      for (int i = 0; i < n; i++) begin
        if (hit) exp_rx.push_back(dbuf[i]);
        wr_byte(dbuf[i], ack);
        chk("data_ack", ack, hit ? 0 : 1);
      end
    end
    if (stp) begin
      m_stop;
      exp_stop++;
      wq;
      chk("busy_after_stop", busy, 0);
      chk("stop_det_count", stop_cnt, exp_stop);
    end
  endtask

  initial begin
    #(20ms);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic ack, r;
    int n;
    logic [7:0] ab;
    #3;
    repeat (4) @(posedge clk);
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_pulses", {rx_valid, tx_req, addr_hit, stop_det, rw}, 0);
    chk("rst_sda", sda, 1);
    rst_n = 1'b1;
    wq;

    dbuf[0] = 8'hA5;
    xfer(8'h78, 1, 0, 1);
    chk("rx_data_a5", rx_data, 8'hA5);

    dbuf[0] = 8'h5A; dbuf[1] = 8'hC3;
    xfer(8'h79, 2, 0, 1);
    chk("sda_released_nack", sda, 1);

    dbuf[0] = 8'h77;
    xfer(8'h50, 1, 0, 1);
    xfer(8'h00, 1, 0, 1);

    dbuf[0] = 8'h11;
    xfer(8'h78, 1, 0, 0);
    chk("rx_data_11", rx_data, 8'h11);
    dbuf[0] = 8'h96;
    xfer(8'h79, 1, 1, 1);

    exp_rw.push_back(1'b1);
    tx_q.push_back(8'h00);
    m_start;
    wr_byte(8'h79, ack);
    chk("rst_test_ack", ack, 0);
    chk("tx_drive_low", sda, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_sda_release", sda, 1);
    #100;
    rst_n = 1'b1;
    chk("rst_mid_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      m_bit(1'b1, 1'b0, r);
      chk("ignored_after_rst", r, 1);
    end
    m_stop;
    exp_stop++;
    wq;
    dbuf[0] = 8'h3E; dbuf[1] = 8'hC1;
    xfer(8'h78, 2, 0, 1);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    exp_rw.push_back(1'b0);
    exp_rx.push_back(8'h6B);
    m_start;
    wr_byte(8'h78, ack);
    chk("glitch_addr_ack", ack, 0);
    glitch_bit = 4;
    wr_byte(8'h6B, ack);
    glitch_bit = -1;
    chk("glitch_data_ack", ack, 0);
    m_stop;
    exp_stop++;
    wq;
    chk("glitch_rx_data", rx_data, 8'h6B);
`endif

    for (int t = 0; t < 16; t++) begin
      ab = ($urandom_range(0, 2) != 0) ? {MY, 1'($urandom_range(0, 1))}
                                       : 8'($urandom);
      n = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) dbuf[i] = 8'($urandom);
      xfer(ab, n, 0, 1);
    end

    repeat (20) @(posedge clk);
    #3;
    chk("rx_q_empty", exp_rx.size(), 0);
    chk("rw_q_empty", exp_rw.size(), 0);
    chk("tx_q_empty", tx_q.size(), 0);
    chk("stop_total", stop_cnt, exp_stop);
    chk("busy_end", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
